// File: rtl/bt656_pkg.sv
// Shared definitions for the bt656_tx sequencing controller: register map,
// control/status bit positions, FSM encoding and pixel-period helper.
package bt656_pkg;

  // Register addresses
  localparam logic [1:0] ADDR_CTRL        = 2'd0;
  localparam logic [1:0] ADDR_FIRST_LINE  = 2'd1;
  localparam logic [1:0] ADDR_STATUS      = 2'd2;
  localparam logic [1:0] ADDR_FRAME_COUNT = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IL_BIT = 1;
  localparam int CTRL_FF_BIT = 2;

  // STATUS bit positions (state occupies [2:0])
  localparam int STATUS_FAULT_BIT = 3;
  localparam int STATUS_PEND_BIT  = 4;

  // FSM encoding, kept as plain constants so the STATUS field is stable
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_RESET = 3'd4;

  // CTRL shadow layout; packed so bit 0 is enable, matching the register
  typedef struct packed {
    logic first_field;
    logic interlace;
    logic enable;
  } ctrl_t;

  // Pixel period in sys cycles: next power of two above the clock ratio,
  // doubled so two periods always contain a full tx pixel clock edge.
  function automatic int pix_period(input int sys_clock, input int pixel_clock);
    return 1 << ($clog2(sys_clock / pixel_clock) + 1);
  endfunction

endpackage

// File: rtl/bt656_sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus rising-edge detect
// on the synchronised value.
module bt656_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the input through the metastability stage, sync stage and history
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and edge-history flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/bt656_tx_ctrl.sv
// Sequencing/configuration controller for one bt656_tx instance. Holds the
// software-visible shadow registers, drives tx reset/start/mode, counts
// frames from the tx V/F flags and only reconfigures at frame boundaries.
module bt656_tx_ctrl
  import bt656_pkg::*;
#(
  parameter int SYS_CLOCK          = 50000000,
  parameter int PIXEL_CLOCK        = 12500000,
  parameter int RST_CYCLES         = 16,
  parameter int WDOG_FIELDS_CYCLES = 2000000
) (
  input  logic        i_SysClock,
  input  logic        i_ResetN,
  input  logic        i_WrEn,
  input  logic        i_RdEn,
  input  logic [1:0]  i_Addr,
  input  logic [31:0] i_WrData,
  output logic [31:0] o_RdData,
  output logic        o_RdValid,
  input  logic        i_Vsignal,
  input  logic        i_Fsignal,
  output logic        o_TxResetN,
  output logic        o_TxValid,
  output logic        o_InterlaceMode,
  output logic        o_FirstField,
  output logic [15:0] o_FirstLine,
  output logic        o_FrameTick,
  output logic        o_Fault
);

  localparam int PIX_PERIOD = pix_period(SYS_CLOCK, PIXEL_CLOCK);
  localparam int ARM_CYCLES = 2 * PIX_PERIOD;
  localparam int CNT_MAX    = (ARM_CYCLES > RST_CYCLES) ? ARM_CYCLES : RST_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int WDOG_W     = $clog2(WDOG_FIELDS_CYCLES + 1);

  // Synchronised tx flags
  logic v_rise, f_sync;
  logic v_sync_unused, f_rise_unused;

  bt656_sync_edge u_sync_v (
    .clk   (i_SysClock),
    .rst_n (i_ResetN),
    .d     (i_Vsignal),
    .sync  (v_sync_unused),
    .rise  (v_rise)
  );

  bt656_sync_edge u_sync_f (
    .clk   (i_SysClock),
    .rst_n (i_ResetN),
    .d     (i_Fsignal),
    .sync  (f_sync),
    .rise  (f_rise_unused)
  );

  // State and counters
  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              fault_q, fault_d;
  logic              pend_q, pend_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic              tick_q, tick_d;

  // Shadow registers
  ctrl_t             ctrl_q, ctrl_d;
  logic [15:0]       first_line_q, first_line_d;

  // Applied tx configuration and tx control
  logic              il_q, il_d;
  logic              ff_q, ff_d;
  logic [15:0]       fl_q, fl_d;
  logic              txrst_q, txrst_d;
  logic              txvalid_q, txvalid_d;

  // Read port
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Decoded bus strobes and events
  logic  wr_ctrl, wr_fl, wr_status, wr_fcnt;
  ctrl_t ctrl_wr_val;
  logic  cfg_change;
  logic  active;
  logic  frame_end;
  logic  wdog_expire;
  logic  unused_wr_bits;

  assign wr_ctrl     = i_WrEn && (i_Addr == ADDR_CTRL);
  assign wr_fl       = i_WrEn && (i_Addr == ADDR_FIRST_LINE);
  assign wr_status   = i_WrEn && (i_Addr == ADDR_STATUS);
  assign wr_fcnt     = i_WrEn && (i_Addr == ADDR_FRAME_COUNT);
  assign ctrl_wr_val = ctrl_t'(i_WrData[2:0]);
  assign cfg_change  = (wr_ctrl && (ctrl_wr_val != ctrl_q)) ||
                       (wr_fl && (i_WrData[15:0] != first_line_q));
  assign active      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // The tx runs in the applied mode, so frame detection follows il_q
  assign frame_end   = v_rise && (il_q ? f_sync : 1'b1);
  assign wdog_expire = active && !v_rise &&
                       (wdog_q == WDOG_W'(WDOG_FIELDS_CYCLES - 1));
  assign unused_wr_bits = ^i_WrData[31:16];

  // Shadow registers, fault flag, frame counter and read data
  always_comb begin
    ctrl_d       = ctrl_q;
    first_line_d = first_line_q;
    if (wr_ctrl) ctrl_d = ctrl_wr_val;
    if (wr_fl)   first_line_d = i_WrData[15:0];

    fault_d = fault_q;
    if (wr_status && i_WrData[STATUS_FAULT_BIT]) fault_d = 1'b0;
    if (wdog_expire) fault_d = 1'b1;

    tick_d      = active && frame_end;
    frame_cnt_d = frame_cnt_q;
    if (active && frame_end) frame_cnt_d = frame_cnt_q + 32'd1;
    if (wr_fcnt) frame_cnt_d = 32'd0;

    wdog_d = (!active || v_rise) ? '0 : wdog_q + WDOG_W'(1);

    rd_valid_d = i_RdEn;
    rd_data_d  = 32'd0;
    if (i_RdEn) begin
      case (i_Addr)
        ADDR_CTRL:        rd_data_d = {29'd0, ctrl_q};
        ADDR_FIRST_LINE:  rd_data_d = {16'd0, first_line_q};
        ADDR_STATUS:      rd_data_d = {27'd0, pend_q, fault_q, state_q};
        default:          rd_data_d = frame_cnt_q;
      endcase
    end
  end

  // Sequencing FSM: ARM/RESET timing, drain to frame end, watchdog abort
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_q.enable && !fault_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (cnt_q == CNT_W'(ARM_CYCLES - 1)) state_d = ST_RUN;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_RUN: begin
        if (wdog_expire) begin
          state_d = ST_RESET;
        end else if (cfg_change || !ctrl_q.enable) begin
          state_d = ST_DRAIN;
          pend_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (wdog_expire || frame_end) state_d = ST_RESET;
      end
      ST_RESET: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          pend_d  = 1'b0;
          state_d = (ctrl_q.enable && !fault_q) ? ST_ARM : ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered tx controls track the next state so they are glitch-free
    txrst_d   = (state_d == ST_ARM) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    txvalid_d = (state_d == ST_ARM);

    il_d = il_q;
    ff_d = ff_q;
    fl_d = fl_q;
    if (state_q == ST_ARM) begin
      il_d = ctrl_q.interlace;
      ff_d = ctrl_q.first_field;
      fl_d = first_line_q;
    end
  end

  // All controller state, asynchronously cleared
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      wdog_q       <= '0;
      fault_q      <= 1'b0;
      pend_q       <= 1'b0;
      frame_cnt_q  <= 32'd0;
      tick_q       <= 1'b0;
      ctrl_q       <= '0;
      first_line_q <= 16'd0;
      il_q         <= 1'b0;
      ff_q         <= 1'b0;
      fl_q         <= 16'd0;
      txrst_q      <= 1'b0;
      txvalid_q    <= 1'b0;
      rd_data_q    <= 32'd0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wdog_q       <= wdog_d;
      fault_q      <= fault_d;
      pend_q       <= pend_d;
      frame_cnt_q  <= frame_cnt_d;
      tick_q       <= tick_d;
      ctrl_q       <= ctrl_d;
      first_line_q <= first_line_d;
      il_q         <= il_d;
      ff_q         <= ff_d;
      fl_q         <= fl_d;
      txrst_q      <= txrst_d;
      txvalid_q    <= txvalid_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign o_RdData        = rd_data_q;
  assign o_RdValid       = rd_valid_q;
  assign o_TxResetN      = txrst_q;
  assign o_TxValid       = txvalid_q;
  assign o_InterlaceMode = il_q;
  assign o_FirstField    = ff_q;
  assign o_FirstLine     = fl_q;
  assign o_FrameTick     = tick_q;
  assign o_Fault         = fault_q;

endmodule

// File: tb/tb_bt656_tx_ctrl.sv
// Directed self-checking bench for bt656_tx_ctrl. The watchdog limit is
// shortened so the fault path is reachable in a short run.
module tb_bt656_tx_ctrl;

  localparam int WDOG = 300;

  logic        clk = 1'b0;
  logic        i_ResetN = 1'b0;
  logic        i_WrEn = 1'b0;
  logic        i_RdEn = 1'b0;
  logic [1:0]  i_Addr = 2'd0;
  logic [31:0] i_WrData = 32'd0;
  logic        i_Vsignal = 1'b0;
  logic        i_Fsignal = 1'b0;
  logic [31:0] o_RdData;
  logic        o_RdValid;
  logic        o_TxResetN;
  logic        o_TxValid;
  logic        o_InterlaceMode;
  logic        o_FirstField;
  logic [15:0] o_FirstLine;
  logic        o_FrameTick;
  logic        o_Fault;

  bt656_tx_ctrl #(
    .SYS_CLOCK          (50000000),
    .PIXEL_CLOCK        (12500000),
    .RST_CYCLES         (16),
    .WDOG_FIELDS_CYCLES (WDOG)
  ) dut (
    .i_SysClock      (clk),
    .i_ResetN        (i_ResetN),
    .i_WrEn          (i_WrEn),
    .i_RdEn          (i_RdEn),
    .i_Addr          (i_Addr),
    .i_WrData        (i_WrData),
    .o_RdData        (o_RdData),
    .o_RdValid       (o_RdValid),
    .i_Vsignal       (i_Vsignal),
    .i_Fsignal       (i_Fsignal),
    .o_TxResetN      (o_TxResetN),
    .o_TxValid       (o_TxValid),
    .o_InterlaceMode (o_InterlaceMode),
    .o_FirstField    (o_FirstField),
    .o_FirstLine     (o_FirstLine),
    .o_FrameTick     (o_FrameTick),
    .o_Fault         (o_Fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse/run-length monitors sampled on the falling edge
  int tick_cnt = 0;
  int low_run = 0;
  int last_low_run = 0;
  int valid_run = 0;
  int last_valid_run = 0;

  always @(negedge clk) begin
    if (o_FrameTick) tick_cnt <= tick_cnt + 1;
    if (!o_TxResetN) low_run <= low_run + 1;
    else if (low_run != 0) begin
      last_low_run <= low_run;
      low_run <= 0;
    end
    if (o_TxValid) valid_run <= valid_run + 1;
    else if (valid_run != 0) begin
      last_valid_run <= valid_run;
      valid_run <= 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    i_WrEn = 1'b1;
    i_Addr = a;
    i_WrData = d;
    step(1);
    i_WrEn = 1'b0;
    i_WrData = 32'd0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    i_RdEn = 1'b1;
    i_Addr = a;
    step(1);
    i_RdEn = 1'b0;
    chk({tag, "_valid"}, {31'd0, o_RdValid}, 32'd1);
    chk(tag, o_RdData, exp);
    step(1);
    chk({tag, "_valid_drop"}, {31'd0, o_RdValid}, 32'd0);
  endtask

  // One field from a minimal tx model: F settles before V rises
  task automatic v_pulse(input logic f);
    i_Fsignal = f;
    step(2);
    i_Vsignal = 1'b1;
    step(3);
    i_Vsignal = 1'b0;
    step(5);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_TxValid && n < 80) begin
      step(1);
      n++;
    end
    chk({tag, "_arm_seen"}, {31'd0, o_TxValid}, 32'd1);
  endtask

  int t0;
  int fault_step;

  initial begin
    // Reset state
    step(3);
    i_ResetN = 1'b1;
    step(2);
    chk("rst_txresetn", {31'd0, o_TxResetN}, 32'd0);
    chk("rst_txvalid", {31'd0, o_TxValid}, 32'd0);
    chk("rst_fault", {31'd0, o_Fault}, 32'd0);
    chk("rst_firstline", {16'd0, o_FirstLine}, 32'd0);
    chk("rst_rdvalid", {31'd0, o_RdValid}, 32'd0);
    rd("rst_status", 2'd2, 32'h0);

    // Start: interlace, first line 4
    wr(2'd1, 32'h4);
    wr(2'd0, 32'h3);
    chk("start_idle_still", {31'd0, o_TxValid}, 32'd0);
    step(20);
    chk("start_valid_len", last_valid_run, 32'd16);
    chk("start_txresetn", {31'd0, o_TxResetN}, 32'd1);
    chk("start_interlace", {31'd0, o_InterlaceMode}, 32'd1);
    chk("start_firstline", {16'd0, o_FirstLine}, 32'd4);
    chk("start_firstfield", {31'd0, o_FirstField}, 32'd0);
    rd("start_status", 2'd2, 32'h2);
    rd("start_ctrl", 2'd0, 32'h3);

    // Interlaced frames: only V rise with F=1 ends a frame
    for (int i = 0; i < 3; i++) begin
      t0 = tick_cnt;
      v_pulse(1'b0);
      chk("tick_f0", tick_cnt - t0, 32'd0);
      t0 = tick_cnt;
      v_pulse(1'b1);
      chk("tick_f1", tick_cnt - t0, 32'd1);
    end
    rd("fcount3", 2'd3, 32'd3);

    // Reconfigure while running: drain to frame end, reset, re-arm
    wr(2'd1, 32'h10);
    step(1);
    chk("recfg_drain_txresetn", {31'd0, o_TxResetN}, 32'd1);
    rd("recfg_status", 2'd2, 32'h13);
    v_pulse(1'b0);
    chk("recfg_f0_no_reset", {31'd0, o_TxResetN}, 32'd1);
    chk("recfg_firstline_old", {16'd0, o_FirstLine}, 32'h4);
    v_pulse(1'b1);
    wait_valid("recfg");
    step(20);
    chk("recfg_low_len", last_low_run, 32'd16);
    chk("recfg_valid_len", last_valid_run, 32'd16);
    chk("recfg_firstline", {16'd0, o_FirstLine}, 32'h10);
    rd("recfg_status_run", 2'd2, 32'h2);

    // Disable mid-frame: DRAIN, then RESET, then IDLE
    wr(2'd0, 32'h0);
    step(1);
    chk("dis_drain_txresetn", {31'd0, o_TxResetN}, 32'd1);
    rd("dis_status", 2'd2, 32'h13);
    v_pulse(1'b1);
    step(30);
    chk("dis_txresetn", {31'd0, o_TxResetN}, 32'd0);
    chk("dis_txvalid", {31'd0, o_TxValid}, 32'd0);
    rd("dis_status_idle", 2'd2, 32'h0);
    rd("fcount5", 2'd3, 32'd5);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("fcount_clr", 2'd3, 32'd0);

    // Watchdog: V held low in RUN
    i_Vsignal = 1'b0;
    wr(2'd0, 32'h3);
    fault_step = 0;
    for (int i = 1; i <= 400; i++) begin
      step(1);
      if (o_Fault && fault_step == 0) fault_step = i;
      if (fault_step != 0) break;
    end
    chk("wdog_fault_time", fault_step, 32'(17 + WDOG));
    step(30);
    rd("wdog_status", 2'd2, 32'h08);
    chk("wdog_txresetn", {31'd0, o_TxResetN}, 32'd0);
    wr(2'd2, 32'h7);
    chk("wdog_keep_fault", {31'd0, o_Fault}, 32'd1);
    wr(2'd2, 32'h8);
    chk("wdog_clear_fault", {31'd0, o_Fault}, 32'd0);
    step(5);
    chk("wdog_rearm_valid", {31'd0, o_TxValid}, 32'd1);
    chk("wdog_rearm_txresetn", {31'd0, o_TxResetN}, 32'd1);
    step(20);
    v_pulse(1'b1);
    rd("fcount1", 2'd3, 32'd1);

    // Reset mid-ARM
    wr(2'd1, 32'h20);
    v_pulse(1'b1);
    wait_valid("rstarm");
    rd("fcount2", 2'd3, 32'd2);
    chk("rstarm_in_arm", {31'd0, o_TxValid}, 32'd1);
    i_ResetN = 1'b0;
    #1;
    chk("arst_txresetn", {31'd0, o_TxResetN}, 32'd0);
    chk("arst_txvalid", {31'd0, o_TxValid}, 32'd0);
    chk("arst_interlace", {31'd0, o_InterlaceMode}, 32'd0);
    chk("arst_firstfield", {31'd0, o_FirstField}, 32'd0);
    chk("arst_firstline", {16'd0, o_FirstLine}, 32'd0);
    chk("arst_rddata", o_RdData, 32'd0);
    chk("arst_rdvalid", {31'd0, o_RdValid}, 32'd0);
    chk("arst_tick", {31'd0, o_FrameTick}, 32'd0);
    chk("arst_fault", {31'd0, o_Fault}, 32'd0);
    step(2);
    i_ResetN = 1'b1;
    step(2);
    rd("arst_fcount", 2'd3, 32'd0);
    rd("arst_status", 2'd2, 32'd0);
    chk("arst_held_reset", {31'd0, o_TxResetN}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
